// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : Execute-stage operand resolver. Selects ALU operands A/B from
//                register data, PC, immediate or constants with EX/MEM and
//                MEM/WB forwarding, then queues the pair in a 2-entry skid
//                buffer with a valid/ready handshake. Also keeps a saturating
//                count of forwarded operands for performance monitoring.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [1:0]        sel_a,
    input  logic [1:0]        sel_b,
    input  logic              exmem_we,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_data,
    input  logic              memwb_we,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    output logic [CNT_W-1:0]  fwd_count
);

    // Operand source encodings
    localparam logic [1:0] SEL_A_REG  = 2'd0;
    localparam logic [1:0] SEL_A_PC   = 2'd1;
    localparam logic [1:0] SEL_B_REG  = 2'd0;
    localparam logic [1:0] SEL_B_IMM  = 2'd1;
    localparam logic [1:0] SEL_B_FOUR = 2'd2;

    // Buffer geometry and counter ceiling
    localparam logic [1:0]       DEPTH   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Forwarding hit flags, resolved register values and selected operands
    logic            a_hit_ex;
    logic            a_hit_wb;
    logic            b_hit_ex;
    logic            b_hit_wb;
    logic [XLEN-1:0] res_a;
    logic [XLEN-1:0] res_b;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [1:0]      fwd_events;

    // Handshake qualifiers
    logic accept;
    logic push;
    logic pop;
    logic [0:0] tail_idx;

    // Skid buffer storage and pointers
    logic [XLEN-1:0] buf_a_q [2];
    logic [XLEN-1:0] buf_a_d [2];
    logic [XLEN-1:0] buf_b_q [2];
    logic [XLEN-1:0] buf_b_d [2];
    logic [0:0]      head_q;
    logic [0:0]      head_d;
    logic [1:0]      count_q;
    logic [1:0]      count_d;

    // Forwarding-event counter
    logic [CNT_W-1:0] fwd_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_d;
    logic [CNT_W:0]   fwd_sum;

    // Forwarding resolution: EX/MEM has priority, x0 is never forwarded
    always_comb begin
        a_hit_ex = exmem_we && (exmem_rd == rs1_addr) && (rs1_addr != '0);
        a_hit_wb = memwb_we && (memwb_rd == rs1_addr) && (rs1_addr != '0);
        b_hit_ex = exmem_we && (exmem_rd == rs2_addr) && (rs2_addr != '0);
        b_hit_wb = memwb_we && (memwb_rd == rs2_addr) && (rs2_addr != '0);

        if (a_hit_ex) begin
            res_a = exmem_data;
        end else if (a_hit_wb) begin
            res_a = memwb_data;
        end else begin
            res_a = rs1_data;
        end

        if (b_hit_ex) begin
            res_b = exmem_data;
        end else if (b_hit_wb) begin
            res_b = memwb_data;
        end else begin
            res_b = rs2_data;
        end
    end

    // Operand source select and per-entry forwarding event tally
    always_comb begin
        case (sel_a)
            SEL_A_REG: src_a = res_a;
            SEL_A_PC:  src_a = pc;
            default:   src_a = '0;
        endcase

        case (sel_b)
            SEL_B_REG:  src_b = res_b;
            SEL_B_IMM:  src_b = imm;
            SEL_B_FOUR: src_b = XLEN'(4);
            default:    src_b = '0;
        endcase

        // Only a register-selected operand counts as a forwarding event
        fwd_events = {1'b0, (sel_a == SEL_A_REG) && (a_hit_ex || a_hit_wb)}
                   + {1'b0, (sel_b == SEL_B_REG) && (b_hit_ex || b_hit_wb)};
    end

    // Handshake: ready depends only on occupancy, never on out_ready
    always_comb begin
        in_ready  = (count_q < DEPTH);
        out_valid = (count_q != 2'd0);
        accept    = in_valid && in_ready;
        push      = accept && !flush;
        pop       = out_valid && out_ready;
        // Next free slot sits one past the head when one entry is held
        tail_idx  = head_q ^ count_q[0];
    end

    // Skid buffer next-state: write tail, advance head, track occupancy
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            buf_a_d[i] = buf_a_q[i];
            buf_b_d[i] = buf_b_q[i];
        end
        head_d  = head_q;
        count_d = count_q;

        if (flush) begin
            head_d  = '0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                buf_a_d[tail_idx] = src_a;
                buf_b_d[tail_idx] = src_b;
            end
            if (pop) begin
                head_d = head_q ^ 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Forwarding counter next-state with saturation; frozen by flush
    always_comb begin
        fwd_sum   = {1'b0, fwd_cnt_q} + (CNT_W + 1)'(fwd_events);
        fwd_cnt_d = fwd_cnt_q;
        if (push) begin
            if (fwd_sum > {1'b0, CNT_MAX}) begin
                fwd_cnt_d = CNT_MAX;
            end else begin
                fwd_cnt_d = fwd_sum[CNT_W-1:0];
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_a_q[i] <= '0;
                buf_b_q[i] <= '0;
            end
            head_q    <= '0;
            count_q   <= 2'd0;
            fwd_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                buf_a_q[i] <= buf_a_d[i];
                buf_b_q[i] <= buf_b_d[i];
            end
            head_q    <= head_d;
            count_q   <= count_d;
            fwd_cnt_q <= fwd_cnt_d;
        end
    end

    // Head entry drives the ALU; outputs read zero when the buffer is empty
    always_comb begin
        op_a      = out_valid ? buf_a_q[head_q] : '0;
        op_b      = out_valid ? buf_b_q[head_q] : '0;
        fwd_count = fwd_cnt_q;
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised successor to the execute-stage ALU input select muxes.
- Resolves both ALU operands (A, B) from register data, PC, immediate or constants, with EX/MEM and MEM/WB forwarding.
- Registers the result into a 2-entry skid buffer with valid/ready handshake, so the operand stage decouples from ALU backpressure.
- Sits between ID/EX decode outputs and the ALU; also carries a saturating forwarding-event counter for performance monitoring.

Parameters:
XLEN, 32, datapath width of all operands and results
REG_AW, 5, register address width
CNT_W, 16, width of forwarding-event counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  decoded instruction operands valid
in_ready  output  1  stage can accept an entry this cycle
rs1_addr  input  REG_AW  source register of operand A
rs2_addr  input  REG_AW  source register of operand B
rs1_data  input  XLEN  register-file read data A
rs2_data  input  XLEN  register-file read data B
pc  input  XLEN  instruction PC
imm  input  XLEN  decoded immediate
sel_a  input  2  A source: 0 reg, 1 pc, 2 zero, 3 zero
sel_b  input  2  B source: 0 reg, 1 imm, 2 constant 4, 3 zero
exmem_we  input  1  EX/MEM stage writes a register
exmem_rd  input  REG_AW  EX/MEM destination
exmem_data  input  XLEN  EX/MEM result
memwb_we  input  1  MEM/WB stage writes a register
memwb_rd  input  REG_AW  MEM/WB destination
memwb_data  input  XLEN  MEM/WB result
out_valid  output  1  operand pair valid
out_ready  input  1  ALU accepts operand pair
op_a  output  XLEN  ALU operand A
op_b  output  XLEN  ALU operand B
fwd_count  output  CNT_W  saturating count of forwarded operands

Behaviour:
- Reset (rst_n low, asynchronous): buffer empty, out_valid=0, op_a=op_b=0, fwd_count=0, in_ready=1.
- Forwarding resolution is combinational on the input side, per operand, in priority order:
  - If exmem_we, exmem_rd==rsN_addr and rsN_addr!=0, use exmem_data.
  - Else if memwb_we, memwb_rd==rsN_addr and rsN_addr!=0, use memwb_data.
  - Else use rsN_data.
  - EX/MEM wins when both stages match. Register x0 is never forwarded.
- Source select:
  - Operand A = resolved reg if sel_a==0; pc if sel_a==1; 0 otherwise.
  - Operand B = resolved reg if sel_b==0; imm if sel_b==1; XLEN'(4) if sel_b==2; 0 if sel_b==3.
  - A forward counts as an event only when the operand's select is 0 (reg); B likewise.
- Skid buffer: 2 entries, FIFO order, occupancy 0..2.
  - in_ready = (occupancy<2). An entry is accepted when in_valid && in_ready.
  - out_valid = (occupancy>0). op_a/op_b come from the head entry and are 0 when empty.
  - An entry is popped when out_valid && out_ready.
  - Latency: data accepted at edge N is visible on op_a/op_b after edge N if the buffer was empty (1 cycle).
  - Push and pop in the same cycle: occupancy unchanged, order preserved. This is legal at occupancy 2 only if in_ready was already 1, so a full buffer does not accept even when popping (no combinational ready path from out_ready).
  - Held outputs remain stable while out_valid && !out_ready.
- flush: at the next edge, occupancy=0 and out_valid=0. A push in the same cycle is dropped. fwd_count is not cleared.
- fwd_count: on each accepted entry, add the number of forwarded reg-selected operands (0, 1 or 2). Saturate at 2^CNT_W-1 with no wrap. Increment is suppressed when flush is asserted the same cycle.
- Reset mid-operation: immediate return to reset values; in-flight entries are lost.
- All arithmetic is unsigned XLEN. The constant 4 is zero-extended.

Test Plan:
- Reset then single push: rs1_addr=3, rs1_data=0x11, sel_a=0, sel_b=1, imm=0x20, out_ready=1 -> after 1 edge out_valid=1, op_a=0x11, op_b=0x20; next edge out_valid=0.
- Dual-stage hazard: rs1_addr=5, exmem_rd=5 (data 0xAA), memwb_rd=5 (data 0xBB), both we=1 -> op_a=0xAA, fwd_count +1. With exmem_we=0 -> op_a=0xBB.
- x0 guard: rs2_addr=0, exmem_rd=0, exmem_we=1, rs2_data=0, sel_b=0 -> op_b=0, fwd_count unchanged.
- Backpressure: out_ready=0, push 3 back-to-back entries 0x1, 0x2, 0x3 -> in_ready=0 after 2 accepted, op_a holds 0x1. Then out_ready=1 -> outputs 0x1 then 0x2; the third entry is accepted once space frees, and order is preserved.
- Flush with occupancy 2 and simultaneous push -> next cycle out_valid=0, in_ready=1, the pushed entry is absent.
- Counter saturation with CNT_W=2: 3 entries each forwarding both operands -> fwd_count 2, then 3, then stays 3. Async reset mid-cycle -> fwd_count=0 and out_valid=0 immediately.
